// File: rtl/fixed_point_pkg.sv
// Shared Q10.10 fixed-point definitions for the multiplier/divider pair:
// format widths, limits, divider state encoding and a magnitude helper.
package fixed_point_pkg;

    localparam int INTEGRAL   = 10;
    localparam int FRACTIONAL = 10;
    localparam int WIDTH      = INTEGRAL + FRACTIONAL;

    // Quotient bits produced by the divider: WIDTH result bits plus the
    // FRACTIONAL bits gained by pre-shifting the dividend.
    localparam int DIV_ITERS  = WIDTH + FRACTIONAL;

    // One extra bit so |-2^(WIDTH-1)| is representable.
    localparam int MAG_W      = WIDTH + 1;
    localparam int CNT_W      = $clog2(DIV_ITERS);

    typedef logic signed [WIDTH-1:0] fixed_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Largest quotient magnitudes that still fit the signed result.
    localparam logic [DIV_ITERS-1:0] MAG_POS_LIMIT =
        {{(DIV_ITERS-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [DIV_ITERS-1:0] MAG_NEG_LIMIT =
        {{(DIV_ITERS-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2
    } div_state_t;

    // Absolute value widened by one bit so the most negative input is exact.
    function automatic logic [MAG_W-1:0] abs_mag(input fixed_t v);
        logic signed [MAG_W-1:0] ext;
        ext = {v[WIDTH-1], v};
        if (v[WIDTH-1]) begin
            return -ext;
        end else begin
            return ext;
        end
    endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module fixed_div_step
    import fixed_point_pkg::*;
(
    input  logic [MAG_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [MAG_W-1:0] divisor_i,
    output logic [MAG_W-1:0] rem_o,
    output logic             qbit_o
);

    logic [MAG_W:0] shifted_s;

    assign shifted_s = {rem_i, bit_i};

    // Trial subtraction: keep the difference and emit 1 when it does not go negative.
    always_comb begin
        rem_o  = shifted_s[MAG_W-1:0];
        qbit_o = 1'b0;
        if (shifted_s >= {1'b0, divisor_i}) begin
            rem_o  = MAG_W'(shifted_s - {1'b0, divisor_i});
            qbit_o = 1'b1;
        end else begin
            rem_o  = shifted_s[MAG_W-1:0];
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_division.sv
// Signed Q10.10 divider, result = (a << FRACTIONAL) / b. Iterative radix-2
// restoring core on magnitudes, sign and saturation applied in a final cycle.
module fixed_division
    import fixed_point_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero
);

    div_state_t             state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [DIV_ITERS-1:0]   dividend_q, dividend_d;
    logic [DIV_ITERS-1:0]   quot_q,     quot_d;
    logic [MAG_W-1:0]       rem_q,      rem_d;
    logic [MAG_W-1:0]       divisor_q,  divisor_d;
    logic                   sign_q,     sign_d;
    logic                   a_neg_q,    a_neg_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic [WIDTH-1:0]       result_q,   result_d;
    logic                   overflow_q, overflow_d;
    logic                   dbz_q,      dbz_d;

    logic [MAG_W-1:0]       abs_a_s;
    logic [MAG_W-1:0]       abs_b_s;
    logic [MAG_W-1:0]       step_rem_s;
    logic                   step_qbit_s;

    assign abs_a_s = abs_mag(a);
    assign abs_b_s = abs_mag(b);

    fixed_div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[DIV_ITERS-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .qbit_o    (step_qbit_s)
    );

    // Next-state, datapath and output logic for the IDLE/DIVIDE/FIX sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        sign_d     = sign_q;
        a_neg_d    = a_neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = DIV_ITERS'({abs_a_s, {FRACTIONAL{1'b0}}});
                    divisor_d  = abs_b_s;
                    rem_d      = {MAG_W{1'b0}};
                    quot_d     = {DIV_ITERS{1'b0}};
                    sign_d     = a[WIDTH-1] ^ b[WIDTH-1];
                    a_neg_d    = a[WIDTH-1];
                    cnt_d      = CNT_W'(DIV_ITERS - 1);
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    dbz_d      = 1'b0;
                    if (b == {WIDTH{1'b0}}) begin
                        state_d = FIX;
                    end else begin
                        state_d = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            DIVIDE: begin
                rem_d      = step_rem_s;
                quot_d     = {quot_q[DIV_ITERS-2:0], step_qbit_s};
                dividend_d = {dividend_q[DIV_ITERS-2:0], 1'b0};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (divisor_q == {MAG_W{1'b0}}) begin
                    // Division by zero saturates toward the sign of the dividend.
                    result_d   = a_neg_q ? FIXED_MIN : FIXED_MAX;
                    dbz_d      = 1'b1;
                    overflow_d = 1'b0;
                end else if (!sign_q) begin
                    if (quot_q > MAG_POS_LIMIT) begin
                        result_d   = FIXED_MAX;
                        overflow_d = 1'b1;
                    end else begin
                        result_d   = WIDTH'(quot_q);
                        overflow_d = 1'b0;
                    end
                end else begin
                    // Exactly -2^(WIDTH-1) still fits, so the limit test is strict.
                    if (quot_q > MAG_NEG_LIMIT) begin
                        result_d   = FIXED_MIN;
                        overflow_d = 1'b1;
                    end else begin
                        result_d   = WIDTH'(~quot_q + {{(DIV_ITERS-1){1'b0}}, 1'b1});
                        overflow_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            dividend_q <= {DIV_ITERS{1'b0}};
            quot_q     <= {DIV_ITERS{1'b0}};
            rem_q      <= {MAG_W{1'b0}};
            divisor_q  <= {MAG_W{1'b0}};
            sign_q     <= 1'b0;
            a_neg_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            sign_q     <= sign_d;
            a_neg_q    <= a_neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
